// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, flag indices,
// FSM encoding, response entry width and the reference ALU function.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Entry = {tag, overflow, carry, zero, result}
  function automatic int rsp_entry_w(input int tag_w);
    return tag_w + 3 + 8;
  endfunction

  // Returns {overflow, carry, zero, result}; SUB carry is the borrow out
  function automatic logic [10:0] alu_model(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [2:0] op);
    logic [8:0] wide;
    logic       v;
    wide = 9'd0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        v    = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        v    = (a[7] != b[7]) && (wide[7] != a[7]);
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SLL:  wide = {1'b0, a << b[2:0]};
      OP_SRL:  wide = {1'b0, a >> b[2:0]};
      default: wide = {1'b0, ~a};
    endcase
    return {v, wide[8], (wide[7:0] == 8'd0), wide[7:0]};
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous show-ahead FIFO; head is valid whenever empty is low.
module alu_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a registered 8-bit ALU and queues tagged
// responses. Define ALU_CHECK_EN to add the golden-model result checker.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef ALU_CHECK_EN
  ,
  output logic             rsp_mismatch,
  output logic [7:0]       err_count
`endif
);

  localparam int WCW = $clog2(ALU_LAT + 1);
  localparam int CW  = $clog2(RSP_DEPTH) + 1;
`ifdef ALU_CHECK_EN
  localparam int EW  = rsp_entry_w(TAG_W) + 1;
`else
  localparam int EW  = rsp_entry_w(TAG_W);
`endif

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             push;
  logic             pop;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == ST_WAIT) && (wait_cnt == '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  // cmd_ready is registered: it predicts next-cycle occupancy from push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      tag_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cmd_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_op;
            tag_q      <= cmd_tag;
            wait_cnt   <= WCW'(ALU_LAT);
            state      <= ST_WAIT;
            cmd_ready  <= 1'b0;
          end else begin
            cmd_ready  <= !(fifo_full && !pop);
          end
        end
        default: begin
          if (wait_cnt != '0) begin
            wait_cnt  <= wait_cnt - 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            cmd_ready <= !((fifo_count == CW'(RSP_DEPTH - 1)) && !pop);
          end
        end
      endcase
    end
  end

`ifdef ALU_CHECK_EN
  logic [10:0] exp_q;
  logic [7:0]  err_q;
  logic        mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign mismatch = (exp_q != {alu_overflow, alu_carry, alu_zero, alu_result});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      err_q <= '0;
    end else begin
      if (accept) exp_q <= alu_model(cmd_a, cmd_b, cmd_op);
      if (push && mismatch) err_q <= sat_inc(err_q);
    end
  end

  assign push_data    = {mismatch, tag_q, alu_overflow, alu_carry, alu_zero, alu_result};
  assign rsp_mismatch = head[EW-1];
  assign err_count    = err_q;
`else
  assign push_data    = {tag_q, alu_overflow, alu_carry, alu_zero, alu_result};
`endif

  alu_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_result = head[7:0];
  assign rsp_flags  = {head[8 + FLG_V], head[8 + FLG_C], head[8 + FLG_Z]};
  assign rsp_tag    = head[11 +: TAG_W];

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Command-side driver for the registered 8-bit ALU.
- Accepts operation commands over a valid/ready interface and drives the ALU operand and opcode inputs.
- Waits out the ALU register latency, then captures result and flags.
- Returns tagged responses through a small response FIFO with its own valid/ready interface.
- Sits between a test or CPU-style sequencer and the ALU. One command is in flight at a time.

Parameters:
- TAG_W, 4, width of the command/response tag.
- RSP_DEPTH, 4, response FIFO depth in entries (power of 2, ≥2).
- ALU_LAT, 1, ALU register stages between the alu_* inputs and the ALU outputs (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 NOT.
- cmd_tag  in  TAG_W  tag returned unchanged with the response.
- alu_a  out  8  to ALU operand A (registered).
- alu_b  out  8  to ALU operand B (registered).
- alu_opcode  out  3  to ALU opcode (registered).
- alu_result  in  8  from ALU.
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  8  captured result.
- rsp_flags  out  3  {overflow, carry, zero}.
- rsp_tag  out  TAG_W  tag of the command.
- busy  out  1  high when not IDLE or FIFO not empty.

Behaviour:
- Reset value of every output and register is 0, including alu_*, FIFO pointers and count, and state=IDLE.
- Reset mid-operation drops the in-flight command and flushes the FIFO; no response is ever emitted for it.
- FSM state IDLE:
  - cmd_ready = (fifo_count < RSP_DEPTH).
  - On cmd_valid&&cmd_ready at edge E0: alu_a/b/opcode ← cmd fields; tag is latched; wait_cnt ← ALU_LAT; go to WAIT.
- FSM state WAIT: cmd_ready=0.
  - wait_cnt decrements by 1 each edge while nonzero.
  - At the edge where wait_cnt==0: push {tag, overflow, carry, zero, result} from the ALU inputs into the FIFO; go to IDLE.
- Timing with ALU_LAT=1: accept at E0, ALU samples at E1, capture at E2, rsp_valid high after E2.
  - Command-to-response latency is ALU_LAT+1 cycles.
  - Maximum throughput is one command per ALU_LAT+2 cycles.
- alu_a/b/opcode hold their last value between commands and change only on accept.
- FIFO:
  - Show-ahead: rsp_* reflect the head entry whenever rsp_valid=1.
  - Pop on rsp_valid&&rsp_ready.
  - Responses are returned in command order.
  - A push and pop in the same cycle leaves the count unchanged.
  - Overflow cannot occur because accept requires a free slot.
  - Pointers wrap modulo RSP_DEPTH.
- rsp_ready while the FIFO is empty has no effect.
- cmd_* are ignored when cmd_ready=0; the sender must hold cmd_* while cmd_valid=1 and not yet accepted.

Optional Feature:
ALU_CHECK_EN
- Defined:
  - A golden model computes the expected result/flags from the cmd fields at accept and registers them.
  - The model's SLL/SRL use b[2:0]; SUB carry = borrow bit 8 of the 9-bit difference.
  - At capture, the model output is compared with the ALU values; the mismatch bit is stored with the FIFO entry.
  - Adds ports rsp_mismatch (out, 1) and err_count (out, 8). err_count is sticky, saturates at 255, and resets to 0.
- Undefined: no model, no extra ports, FIFO entry width excludes the mismatch bit.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD..OP_NOT.
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2.
  - the FSM state encoding.
  - the response entry width function of TAG_W.
- Sub-module alu_rsp_fifo: a generic synchronous show-ahead FIFO with WIDTH/DEPTH parameters, push/pop/full/empty/count.

Test Plan:
1. Reset, ADD a=0x7F b=0x01 tag=3 → two cycles after accept: rsp_result=0x80, flags V=1 C=0 Z=0, rsp_tag=3.
2. SUB 0x05−0x05 → 0x00, Z=1 C=0. Then SUB 0x00−0x01 → 0xFF, C=1 V=0. Then ADD 0xFF+0x01 → 0x00, Z=1 C=1.
3. rsp_ready=0, five back-to-back ADD commands tags 0..4 → four accepted, cmd_ready stays 0. Raise rsp_ready → tags 0,1,2,3 in order, then tag 4 accepted and returned.
4. Assert rst_n=0 while in WAIT → all outputs 0 asynchronously, FIFO empty, no response after release. The next command completes normally.
5. SLL a=0x81 b=0x09 → 0x02; SRL a=0x80 b=0x07 → 0x01; NOT a=0xFF → 0x00 with Z=1. Carry and overflow are 0 for all three.
6. ALU_CHECK_EN, force alu_result=0x00 for an AND 0xF0&0x3C → rsp_mismatch=1, err_count=1. Force 300 mismatches → err_count=255.
